ruta_datos_mult: RTL

RUTA_DATOS_MULT -- requirements
Module: ruta_datos_mult

---
 rtl/ruta_datos_mult.sv | 79 +++++++
 1 files changed

// File: rtl/ruta_datos_mult.sv
// Datapath for a shift-and-add multiplier. The external control unit sequences it
// through the CargaQ, DesplazaQ, ResetA, CargaA and Fin strobes.
module ruta_datos_mult #(
    parameter int unsigned N = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     Multiplicando,
    input  logic [N-1:0]     Multiplicador,
    input  logic             CargaQ,
    input  logic             DesplazaQ,
    input  logic             ResetA,
    input  logic             CargaA,
    input  logic             Fin,
    output logic             q0,
    output logic [2*N-1:0]   Producto,
    output logic             Valido,
    output logic             Ocupado
);

    localparam int unsigned W = 2 * N;

    logic [N-1:0] q;
    logic [W-1:0] m;
    logic [W-1:0] a;
    logic         fin_d;
    logic         capture_c;

    // The control unit decides CargaA from the current Q[0], so no register delay here.
    assign q0        = q[0];
    assign capture_c = Fin & ~fin_d;

    // Multiplier register Q and multiplicand register M; a load wins over a shift.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= '0;
            m <= '0;
        end else if (CargaQ) begin
            q <= Multiplicador;
            m <= W'(Multiplicando);
        end else if (DesplazaQ) begin
            q <= q >> 1;
            m <= m << 1;
        end
    end

    // Accumulator; the sum uses the pre-shift M when a shift happens on the same edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a <= '0;
        end else if (ResetA) begin
            a <= '0;
        end else if (CargaA) begin
            a <= a + m;
        end
    end

    // Result capture on the rising edge of Fin, with a one-cycle Valido pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fin_d    <= 1'b0;
            Producto <= '0;
            Valido   <= 1'b0;
            Ocupado  <= 1'b0;
        end else begin
            fin_d  <= Fin;
            Valido <= capture_c;
            if (capture_c) begin
                Producto <= a;
            end
            if (CargaQ) begin
                Ocupado <= 1'b1;
            end else if (capture_c) begin
                Ocupado <= 1'b0;
            end
        end
    end

endmodule
